spike_network: RTL and testbench
================================

// Module: spike_network
// PURPOSE
//  Arbitration/broadcast stage between the neuron array and the neuron inputs.
//  Waits until every active neuron requests a network step (en_network).
//  Scans their 2-bit spike codes round-robin and picks one spiking neuron.
//  Broadcasts {spike, id} on the shared spike bus, then pulses networkDone so all neurons enter their receive phase.
// PARAMETERS
//  TEN_DATA_WIDTH   2    spike code width (0 none, 1 positive, 2 negative, 3 invalid)
//  NUM_NEURON       128  physical neuron count
//  NEURON_ID_WIDTH  7    neuron index width
//  CNT_WIDTH        16   width of statistics counters
// PORTS
//  clk              in   1                        system clock
//  reset            in   1                        synchronous, active-high reset
//  en               in   1                        global enable; 0 freezes all state (outputs hold)
//  active_neuron    in   NEURON_ID_WIDTH          number of neurons in use (indices 0..active_neuron-1)
//  en_network_vec   in   NUM_NEURON               en_network from each neuron
//  spike_vec        in   NUM_NEURON*TEN_DATA_WIDTH spike_out of neuron i at [i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH]
//  spike_bcast      out  TEN_DATA_WIDTH+NEURON_ID_WIDTH  {code, id} to every neuron's spike_in, registered
//  networkDone      out  1                        one-cycle pulse: broadcast valid, step complete
//  busy             out  1                        high in SCAN/DONE/DRAIN
//  spike_count      out  CNT_WIDTH                number of non-null broadcasts, saturating
//  step_count       out  CNT_WIDTH                number of completed steps, wraps
// BEHAVIOUR
//  Reset: state IDLE; spike_bcast=0, networkDone=0, busy=0, counters=0, rr pointer=0.
//  The reset takes effect mid-scan in the same way (abort, no done pulse).
//  all_req = AND of en_network_vec[i] over i<active_neuron; all_idle = NOR over the same mask.
//  IDLE: if all_req and active_neuron!=0 -> SCAN.
//    Latch N=active_neuron, idx=ptr (ptr>=N forces idx=0), cnt=0.
//    If all_req and active_neuron==0 -> DONE with null broadcast.
//  SCAN: examine code=spike_vec[idx], one neuron per cycle.
//    code 1 or 2: latch spike_bcast={code,idx}, go to DONE.
//    code 0 or 3: the neuron is skipped.
//      If cnt==N-1: latch spike_bcast=0 and go to DONE.
//      Otherwise: cnt++, idx = (idx+1==N) ? 0 : idx+1.
//  DONE: networkDone=1 for exactly this cycle.
//    Update ptr: winner id+1, wrapped at N; unchanged on a null broadcast.
//    step_count++. spike_count++ if non-null, saturating at all-ones. Then go to DRAIN.
//  DRAIN: wait for all_idle. Neurons drop en_network combinationally on networkDone, so this normally takes one cycle. Then go to IDLE.
//  spike_bcast holds from its latch until the next SCAN latch. It therefore stays stable through the neurons' receive phase.
//  Latency: start to networkDone = 1 + (position of winner after ptr) + 1 cycles. Worst case N+1 cycles.
//  N and ptr are sampled at SCAN entry. A change to active_neuron mid-scan affects only the next step.
//  en=0 in any state: no transition, no counter change. networkDone stays registered-high only if it was already high. No new pulse is generated.
//  A spike_vec change during SCAN is used as sampled. Neurons hold spike_out in NETWORK, so it is stable.
//  Unused neurons (index>=active_neuron) are ignored for both request and scan.
// STRUCTURE
//  Shared package: spike codes SPK_NONE/SPK_POS/SPK_NEG, SPIKE_IN_WIDTH=TEN_DATA_WIDTH+NEURON_ID_WIDTH, state encoding IDLE/SCAN/DONE/DRAIN.
//  Sub-module spike_sel_mux (combinational): it selects the spike code for a given idx and computes the masked all_req/all_idle.
//  FSM, pointer and counters live in this module.
// TESTING
//  1: N=8, ptr=0, only neuron 5 code 1 -> networkDone at cycle 7 after start; bcast={1,5}; ptr becomes 6.
//  2: N=8, ptr=6, neurons 2 and 7 code 2 -> bcast={2,7}, ptr wraps to 0; next step picks neuron 2.
//  3: N=4, all codes 0 or 3 -> bcast=0 after 4 SCAN cycles; spike_count unchanged; step_count +1.
//  4: active_neuron=0 -> immediate null broadcast. Separately, en_network of neuron 3 held low with N=8 -> stays IDLE.
//  5: reset asserted during SCAN -> next cycle IDLE with all outputs 0 and no networkDone.
//     en=0 for 3 cycles mid-scan -> done is delayed by exactly 3 cycles.
//  6: with spike_count preloaded near saturation, 2 more spikes -> count stays all-ones.

Source files
------------

// File: rtl/spike_network_pkg.sv
// Shared constants and types for the spike arbitration/broadcast stage.
// Spike codes, bus widths and the FSM state encoding live here.
package spike_network_pkg;

    localparam int TEN_DATA_WIDTH  = 2;
    localparam int NEURON_ID_WIDTH = 7;
    localparam int SPIKE_IN_WIDTH  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
    localparam int DEF_NUM_NEURON  = 128;
    localparam int DEF_CNT_WIDTH   = 16;

    localparam logic [TEN_DATA_WIDTH-1:0] SPK_NONE = 2'd0;
    localparam logic [TEN_DATA_WIDTH-1:0] SPK_POS  = 2'd1;
    localparam logic [TEN_DATA_WIDTH-1:0] SPK_NEG  = 2'd2;
    localparam logic [TEN_DATA_WIDTH-1:0] SPK_INV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Only positive and negative codes count as spikes; none and invalid are skipped.
    function automatic logic is_spike(input logic [TEN_DATA_WIDTH-1:0] code);
        return (code == SPK_POS) || (code == SPK_NEG);
    endfunction

endpackage

// File: rtl/spike_network_spike_sel_mux.sv
// Combinational helper: picks the spike code of neuron i_idx and reduces the
// en_network requests over the active neurons into all_req / all_idle.
module spike_sel_mux
    import spike_network_pkg::*;
#(
    parameter int NUM_NEURON = DEF_NUM_NEURON
) (
    input  logic [NEURON_ID_WIDTH-1:0]           i_active_neuron,
    input  logic [NEURON_ID_WIDTH-1:0]           i_idx,
    input  logic [NUM_NEURON-1:0]                i_en_network_vec,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0] i_spike_vec,
    output logic [TEN_DATA_WIDTH-1:0]            o_code,
    output logic                                 o_all_req,
    output logic                                 o_all_idle
);

    // An empty mask (active_neuron == 0) yields all_req = all_idle = 1.
    always_comb begin
        o_all_req  = 1'b1;
        o_all_idle = 1'b1;
        o_code     = SPK_NONE;
        for (int i = 0; i < NUM_NEURON; i++) begin
            if (i < int'(i_active_neuron)) begin
                if (!i_en_network_vec[i]) o_all_req  = 1'b0;
                if (i_en_network_vec[i])  o_all_idle = 1'b0;
            end
            if (i_idx == NEURON_ID_WIDTH'(i)) begin
                o_code = i_spike_vec[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/spike_network.sv
// Round-robin spike arbiter: waits for every active neuron to request a network
// step, picks one spiking neuron, broadcasts {code,id} and pulses o_network_done.
module spike_network
    import spike_network_pkg::*;
#(
    parameter int NUM_NEURON = DEF_NUM_NEURON,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_en,
    input  logic [NEURON_ID_WIDTH-1:0]           i_active_neuron,
    input  logic [NUM_NEURON-1:0]                i_en_network_vec,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0] i_spike_vec,
    output logic [SPIKE_IN_WIDTH-1:0]            o_spike_bcast,
    output logic                                 o_network_done,
    output logic                                 o_busy,
    output logic [CNT_WIDTH-1:0]                 o_spike_count,
    output logic [CNT_WIDTH-1:0]                 o_step_count,
    output state_t                               o_state
);

    // Handshake: neurons raise en_network to request a step and must hold it
    // (and their spike code) until o_network_done; they drop it in response to
    // that pulse, and the arbiter waits in DRAIN until all active requests are low.

    state_t                     r_state;
    logic [NEURON_ID_WIDTH-1:0] r_n;
    logic [NEURON_ID_WIDTH-1:0] r_idx;
    logic [NEURON_ID_WIDTH-1:0] r_cnt;
    logic [NEURON_ID_WIDTH-1:0] r_ptr;
    logic                       r_hit;
    logic [SPIKE_IN_WIDTH-1:0]  r_bcast;
    logic                       r_done;
    logic                       r_busy;
    logic [CNT_WIDTH-1:0]       r_spike_cnt;
    logic [CNT_WIDTH-1:0]       r_step_cnt;

    logic [TEN_DATA_WIDTH-1:0]  w_code;
    logic                       w_all_req;
    logic                       w_all_idle;
    logic [NEURON_ID_WIDTH-1:0] w_idx_next;
    logic [NEURON_ID_WIDTH-1:0] w_win_next;

    spike_sel_mux #(.NUM_NEURON(NUM_NEURON)) u_sel (
        .i_active_neuron (i_active_neuron),
        .i_idx           (r_idx),
        .i_en_network_vec(i_en_network_vec),
        .i_spike_vec     (i_spike_vec),
        .o_code          (w_code),
        .o_all_req       (w_all_req),
        .o_all_idle      (w_all_idle)
    );

    assign w_idx_next = r_idx + 1'b1;
    assign w_win_next = r_bcast[NEURON_ID_WIDTH-1:0] + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_hit       <= 1'b0;
            r_bcast     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_spike_cnt <= '0;
            r_step_cnt  <= '0;
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_all_req) begin
                        r_busy <= 1'b1;
                        if (i_active_neuron != '0) begin
                            r_state <= ST_SCAN;
                            r_n     <= i_active_neuron;
                            r_idx   <= (r_ptr >= i_active_neuron) ? '0 : r_ptr;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_DONE;
                            r_bcast <= '0;
                            r_hit   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (is_spike(w_code)) begin
                        r_bcast <= {w_code, r_idx};
                        r_hit   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == r_n - 1'b1) begin
                        r_bcast <= '0;
                        r_hit   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_idx <= (w_idx_next == r_n) ? '0 : w_idx_next;
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_state    <= ST_DRAIN;
                    r_step_cnt <= r_step_cnt + 1'b1;
                    if (r_hit) begin
                        r_ptr <= (w_win_next == r_n) ? '0 : w_win_next;
                        if (r_spike_cnt != '1) r_spike_cnt <= r_spike_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_all_idle) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_spike_bcast  = r_bcast;
    assign o_network_done = r_done;
    assign o_busy         = r_busy;
    assign o_spike_count  = r_spike_cnt;
    assign o_step_count   = r_step_cnt;
    assign o_state        = r_state;

endmodule

// File: tb/tb_spike_network.sv
// Randomized self-checking bench for spike_network against a round-robin
// reference model built from plain modulo arithmetic over a code array.
module tb_spike_network;
    import spike_network_pkg::*;

    localparam int NN = 128;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       en = 1'b1;
    logic [NEURON_ID_WIDTH-1:0] active_neuron = '0;
    logic [NN-1:0]              tb_req = '0;
    logic [NN-1:0]              en_network_vec;
    logic [NN*TEN_DATA_WIDTH-1:0] spike_vec = '0;
    logic [SPIKE_IN_WIDTH-1:0]  spike_bcast;
    logic                       network_done;
    logic                       busy;
    logic [CW-1:0]              spike_count;
    logic [CW-1:0]              step_count;
    state_t                     state;

    int n_tests = 0;
    int n_fail  = 0;
    int codes[NN];
    int m_ptr = 0;
    int m_spk = 0;
    int m_stp = 0;
    logic [SPIKE_IN_WIDTH-1:0] exp_q[$];

    // Neurons drop their request combinationally on the done pulse.
    assign en_network_vec = network_done ? '0 : tb_req;

    spike_network #(.NUM_NEURON(NN), .CNT_WIDTH(CW)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_en            (en),
        .i_active_neuron (active_neuron),
        .i_en_network_vec(en_network_vec),
        .i_spike_vec     (spike_vec),
        .o_spike_bcast   (spike_bcast),
        .o_network_done  (network_done),
        .o_busy          (busy),
        .o_spike_count   (spike_count),
        .o_step_count    (step_count),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_inputs(input int n, input logic [NN-1:0] req);
        logic [1:0] c;
        active_neuron = NEURON_ID_WIDTH'(n);
        for (int i = 0; i < NN; i++) begin
            c = codes[i][1:0];
            spike_vec[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH] = c;
        end
        tb_req = req;
    endtask

    function automatic logic [NN-1:0] req_mask(input int n);
        logic [NN-1:0] m;
        for (int i = 0; i < NN; i++) m[i] = (i < n) ? 1'b1 : 1'($urandom_range(0, 1));
        return m;
    endfunction

    // One complete network step; hold_at > 0 freezes the DUT for 3 cycles at that cycle.
    task automatic run_step(input string tag, input int n, input int hold_at);
        int start, win, exp_lat, cyc, k;
        logic [1:0] wc;
        logic [SPIKE_IN_WIDTH-1:0] eb;
        bit got;
        start = (m_ptr >= n) ? 0 : m_ptr;
        win = -1;
        exp_lat = 0;
        for (k = 0; k < n; k++) begin
            if (codes[(start + k) % n] == 1 || codes[(start + k) % n] == 2) begin
                win = (start + k) % n;
                exp_lat = k + 2;
                break;
            end
        end
        if (n == 0) exp_lat = 1;
        else if (win < 0) exp_lat = n + 1;
        if (hold_at > 0) exp_lat += 3;
        if (win < 0) eb = '0;
        else begin
            wc = codes[win][1:0];
            eb = {wc, NEURON_ID_WIDTH'(win)};
        end
        exp_q.push_back(eb);
        load_inputs(n, req_mask(n));
        cyc = 0;
        got = 0;
        while (cyc < 400 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (network_done) got = 1;
            else if (cyc == hold_at) begin
                en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                cyc += 3;
                en = 1'b1;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_bcast"}, 32'(spike_bcast), 32'(exp_q.pop_front()));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (win >= 0) begin
            m_ptr = (win + 1) % n;
            if (m_spk < CNT_MAX) m_spk++;
        end
        m_stp = (m_stp + 1) % (CNT_MAX + 1);
        tb_req = '0;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(network_done), 32'd0);
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(state == ST_IDLE), 32'd1);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(spike_bcast), 32'(eb));
        check({tag, "_spk_cnt"}, 32'(spike_count), 32'(m_spk));
        check({tag, "_stp_cnt"}, 32'(step_count), 32'(m_stp));
    endtask

    task automatic clear_codes();
        for (int i = 0; i < NN; i++) codes[i] = 0;
    endtask

    initial begin
        int seen;
        clear_codes();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state == ST_IDLE), 32'd1);
        check("rst_bcast", 32'(spike_bcast), 32'd0);
        check("rst_done", 32'(network_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_counts", {16'(spike_count), 16'(step_count)}, 32'd0);
        reset = 1'b0;

        // Single spiker at 5 from ptr 0, then two spikers across the wrap point.
        codes[5] = 1;
        run_step("t1", 8, 0);
        clear_codes();
        codes[2] = 2; codes[7] = 2;
        run_step("t2a", 8, 0);
        run_step("t2b", 8, 0);
        // No valid spike among 4 neurons; invalid codes are skipped.
        clear_codes();
        codes[1] = 3; codes[3] = 3; codes[6] = 1;
        run_step("t3", 4, 0);
        run_step("t4_zero", 0, 0);

        // One active neuron not requesting: the step never starts.
        active_neuron = 7'd8;
        tb_req = '1;
        tb_req[3] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (network_done || busy) seen++;
        end
        check("t4_stall", seen, 0);
        check("t4_stall_state", 32'(state == ST_IDLE), 32'd1);
        tb_req = '0;

        // Reset mid-scan aborts the step without a done pulse.
        clear_codes();
        codes[5] = 1;
        load_inputs(8, req_mask(8));
        repeat (3) @(posedge clk);
        #1;
        check("t5_scanning", 32'(state == ST_SCAN), 32'd1);
        reset = 1'b1;
        tb_req = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0; m_spk = 0; m_stp = 0;
        check("t5_rst_state", 32'(state == ST_IDLE), 32'd1);
        check("t5_rst_out", {23'd0, 32'(spike_bcast)} | 32'({network_done, busy} << 9), 32'd0);
        check("t5_rst_cnt", {16'(spike_count), 16'(step_count)}, 32'd0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (network_done) seen++;
        end
        check("t5_no_done", seen, 0);
        // Same step with en low for 3 cycles mid-scan: done 3 cycles later.
        run_step("t5_hold", 8, 3);

        // Random steps; the small counter width drives saturation and wrap.
        for (int s = 0; s < 40; s++) begin
            int n, r;
            for (int i = 0; i < NN; i++) begin
                r = $urandom_range(0, 9);
                codes[i] = (r < 2) ? $urandom_range(1, 2) : (($urandom_range(0, 1) == 1) ? 3 : 0);
            end
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r < 3) ? $urandom_range(1, 127) : $urandom_range(1, 12);
            run_step("rnd", n, 0);
        end

        // Two guaranteed spikes on top of a saturated count.
        clear_codes();
        codes[0] = 1; codes[1] = 2;
        run_step("t6a", 2, 0);
        run_step("t6b", 2, 0);
        check("t6_saturated", 32'(spike_count), 32'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
